// File: rtl/tl_rx_cpl_tag_tracker.sv
// Completion tag tracker: allocates request tags, classifies received completions
// as expected/unexpected and reports completion timeouts per tag.
module tl_rx_cpl_tag_tracker #(
  parameter int REQUESTER_ID_WIDTH  = 16,
  parameter int REQUESTER_TAG_WIDTH = 10,
  parameter int NUM_TAGS            = 32,
  parameter int TICK_DIV            = 1024,
  parameter int TIMEOUT_TICKS       = 8
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [REQUESTER_ID_WIDTH-1:0]    cfg_requester_id,
  input  logic                             uc_en,
  input  logic                             alloc_req,
  output logic                             alloc_gnt,
  output logic [REQUESTER_TAG_WIDTH-1:0]   alloc_tag,
  input  logic                             cpl_valid,
  input  logic [REQUESTER_ID_WIDTH-1:0]    cpl_req_id,
  input  logic [REQUESTER_TAG_WIDTH-1:0]   cpl_tag,
  input  logic                             cpl_last,
  output logic                             cpl_expected,
  output logic                             cpl_unexpected,
  output logic [REQUESTER_TAG_WIDTH-1:0]   cpl_res_tag,
  output logic                             timeout_valid,
  output logic [REQUESTER_TAG_WIDTH-1:0]   timeout_tag,
  output logic [$clog2(NUM_TAGS):0]        outstanding_count,
  output logic                             all_busy
);

  localparam int          IW         = (NUM_TAGS > 1) ? $clog2(NUM_TAGS) : 1;
  localparam int          CW         = $clog2(NUM_TAGS) + 1;
  localparam int          PW         = $clog2(TICK_DIV);
  localparam logic [31:0] NUM_TAGS_U = 32'(NUM_TAGS);

  typedef enum logic [1:0] {
    ST_FREE      = 2'd0,
    ST_BUSY      = 2'd1,
    ST_TIMED_OUT = 2'd2
  } tag_state_e;

  tag_state_e                 state_r     [NUM_TAGS];
  tag_state_e                 state_nxt_s [NUM_TAGS];
  logic [3:0]                 age_r       [NUM_TAGS];
  logic [3:0]                 age_nxt_s   [NUM_TAGS];
  logic [PW-1:0]              presc_r;
  logic                       tick_s;
  logic                       free_any_s;
  logic [IW-1:0]              free_idx_s;
  logic                       to_any_s;
  logic [IW-1:0]              to_idx_s;
  logic                       grant_s;
  logic                       match_s;
  logic [IW-1:0]              cpl_idx_s;
  logic [CW-1:0]              count_nxt_s;
  logic                       cpl_expected_r;
  logic                       cpl_unexpected_r;
  logic [REQUESTER_TAG_WIDTH-1:0] cpl_res_tag_r;
  logic                       timeout_valid_r;
  logic [REQUESTER_TAG_WIDTH-1:0] timeout_tag_r;
  logic [CW-1:0]              outstanding_count_r;
  logic                       all_busy_r;

  assign tick_s    = (presc_r == PW'(TICK_DIV - 1));
  assign cpl_idx_s = cpl_tag[IW-1:0];

  // Per-tag state and age registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_TAGS; i++) begin
        state_r[i] <= ST_FREE;
        age_r[i]   <= 4'd0;
      end
    end else begin
      for (int i = 0; i < NUM_TAGS; i++) begin
        state_r[i] <= state_nxt_s[i];
        age_r[i]   <= age_nxt_s[i];
      end
    end
  end

  // Output decode: lowest FREE / TIMED_OUT entry, grant and completion match
  always_comb begin
    free_any_s = 1'b0;
    free_idx_s = {IW{1'b0}};
    to_any_s   = 1'b0;
    to_idx_s   = {IW{1'b0}};
    for (int i = NUM_TAGS - 1; i >= 0; i--) begin
      case (state_r[i])
        ST_FREE: begin
          free_any_s = 1'b1;
          free_idx_s = IW'(i);
        end
        ST_TIMED_OUT: begin
          to_any_s = 1'b1;
          to_idx_s = IW'(i);
        end
        default: ;
      endcase
    end
    grant_s   = alloc_req & free_any_s;
    alloc_gnt = grant_s;
    alloc_tag = REQUESTER_TAG_WIDTH'(free_idx_s);
    // Match uses the state at cycle start, so a tag granted this cycle cannot match
    match_s   = cpl_valid & (cpl_req_id == cfg_requester_id) &
                (32'(cpl_tag) < NUM_TAGS_U) & (state_r[cpl_idx_s] == ST_BUSY);
  end

  // Next-state logic for every tag entry plus the resulting occupancy
  always_comb begin
    count_nxt_s = {CW{1'b0}};
    for (int i = 0; i < NUM_TAGS; i++) begin
      state_nxt_s[i] = state_r[i];
      age_nxt_s[i]   = age_r[i];
      case (state_r[i])
        ST_FREE: begin
          if (grant_s && (free_idx_s == IW'(i))) begin
            state_nxt_s[i] = ST_BUSY;
            age_nxt_s[i]   = 4'd0;
          end else begin
            state_nxt_s[i] = ST_FREE;
          end
        end
        ST_BUSY: begin
          if (match_s && cpl_last && (cpl_idx_s == IW'(i))) begin
            state_nxt_s[i] = ST_FREE;
          end else if (tick_s) begin
            age_nxt_s[i] = age_r[i] + 4'd1;
            if ((age_r[i] + 4'd1) == 4'(TIMEOUT_TICKS)) begin
              state_nxt_s[i] = ST_TIMED_OUT;
            end else begin
              state_nxt_s[i] = ST_BUSY;
            end
          end else begin
            state_nxt_s[i] = ST_BUSY;
          end
        end
        ST_TIMED_OUT: begin
          if (to_idx_s == IW'(i)) begin
            state_nxt_s[i] = ST_FREE;
          end else begin
            state_nxt_s[i] = ST_TIMED_OUT;
          end
        end
        default: begin
          state_nxt_s[i] = ST_FREE;
          age_nxt_s[i]   = 4'd0;
        end
      endcase
      count_nxt_s = count_nxt_s + {{(CW-1){1'b0}}, (state_nxt_s[i] != ST_FREE)};
    end
  end

  // Free-running age prescaler
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      presc_r <= {PW{1'b0}};
    end else begin
      presc_r <= tick_s ? {PW{1'b0}} : presc_r + {{(PW-1){1'b0}}, 1'b1};
    end
  end

  // Registered completion/timeout reports and occupancy status
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cpl_expected_r      <= 1'b0;
      cpl_unexpected_r    <= 1'b0;
      cpl_res_tag_r       <= {REQUESTER_TAG_WIDTH{1'b0}};
      timeout_valid_r     <= 1'b0;
      timeout_tag_r       <= {REQUESTER_TAG_WIDTH{1'b0}};
      outstanding_count_r <= {CW{1'b0}};
      all_busy_r          <= 1'b0;
    end else begin
      cpl_expected_r      <= match_s;
      cpl_unexpected_r    <= cpl_valid & ~match_s & uc_en;
      cpl_res_tag_r       <= cpl_valid ? cpl_tag : {REQUESTER_TAG_WIDTH{1'b0}};
      timeout_valid_r     <= to_any_s;
      timeout_tag_r       <= REQUESTER_TAG_WIDTH'(to_idx_s);
      outstanding_count_r <= count_nxt_s;
      all_busy_r          <= (count_nxt_s == CW'(NUM_TAGS));
    end
  end

  assign cpl_expected      = cpl_expected_r;
  assign cpl_unexpected    = cpl_unexpected_r;
  assign cpl_res_tag       = cpl_res_tag_r;
  assign timeout_valid     = timeout_valid_r;
  assign timeout_tag       = timeout_tag_r;
  assign outstanding_count = outstanding_count_r;
  assign all_busy          = all_busy_r;

endmodule

// File: tb/tb_tl_rx_cpl_tag_tracker.sv
// Bench for tl_rx_cpl_tag_tracker: directed scenarios with literal expectations,
// then randomized traffic compared every cycle against a tag-list model.
module tb_tl_rx_cpl_tag_tracker;

  localparam int IDW = 16;
  localparam int TW  = 10;
  localparam int NT  = 4;
  localparam int TD  = 4;
  localparam int TO  = 3;
  localparam int CW  = 3;
  localparam logic [IDW-1:0] OWN = 16'hA5C3;

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic [IDW-1:0] cfg_requester_id = OWN;
  logic           uc_en = 1'b1;
  logic           alloc_req = 1'b0;
  logic           alloc_gnt;
  logic [TW-1:0]  alloc_tag;
  logic           cpl_valid = 1'b0;
  logic [IDW-1:0] cpl_req_id = '0;
  logic [TW-1:0]  cpl_tag = '0;
  logic           cpl_last = 1'b0;
  logic           cpl_expected, cpl_unexpected, timeout_valid, all_busy;
  logic [TW-1:0]  cpl_res_tag, timeout_tag;
  logic [CW-1:0]  outstanding_count;

  tl_rx_cpl_tag_tracker #(
    .REQUESTER_ID_WIDTH(IDW), .REQUESTER_TAG_WIDTH(TW), .NUM_TAGS(NT),
    .TICK_DIV(TD), .TIMEOUT_TICKS(TO)
  ) dut (
    .clk(clk), .rst(rst), .cfg_requester_id(cfg_requester_id), .uc_en(uc_en),
    .alloc_req(alloc_req), .alloc_gnt(alloc_gnt), .alloc_tag(alloc_tag),
    .cpl_valid(cpl_valid), .cpl_req_id(cpl_req_id), .cpl_tag(cpl_tag), .cpl_last(cpl_last),
    .cpl_expected(cpl_expected), .cpl_unexpected(cpl_unexpected), .cpl_res_tag(cpl_res_tag),
    .timeout_valid(timeout_valid), .timeout_tag(timeout_tag),
    .outstanding_count(outstanding_count), .all_busy(all_busy)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Model: each tag is 0=free, 1=outstanding, 2=timed out; m_tk counts ticks since grant
  int   m_st [NT];
  int   m_tk [NT];
  int   m_cyc;
  logic e_cexp, e_cunexp, e_to, e_allbusy;
  int   e_restag, e_totag, e_count;

  function automatic int lowest_free();
    for (int i = 0; i < NT; i++) if (m_st[i] == 0) return i;
    return -1;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NT; i++) begin m_st[i] = 0; m_tk[i] = 0; end
    m_cyc = 0;
    e_cexp = 1'b0; e_cunexp = 1'b0; e_to = 1'b0; e_allbusy = 1'b0;
    e_restag = 0; e_totag = 0; e_count = 0;
  endtask

  task automatic model_step();
    bit tick, match, gnt;
    int g, t_o;
    tick  = (m_cyc % TD) == TD - 1;
    m_cyc++;
    g     = lowest_free();
    gnt   = alloc_req && (g >= 0);
    match = cpl_valid && (cpl_req_id == cfg_requester_id) && (cpl_tag < NT) && (m_st[cpl_tag] == 1);
    e_cexp   = match;
    e_cunexp = cpl_valid && !match && uc_en;
    e_restag = cpl_valid ? int'(cpl_tag) : 0;
    t_o = -1;
    for (int i = NT - 1; i >= 0; i--) if (m_st[i] == 2) t_o = i;
    e_to    = (t_o >= 0);
    e_totag = e_to ? t_o : 0;
    if (t_o >= 0) m_st[t_o] = 0;
    for (int i = 0; i < NT; i++) begin
      if (m_st[i] == 1) begin
        if (match && cpl_tag == i && cpl_last) m_st[i] = 0;
        else if (tick) begin
          m_tk[i]++;
          if (m_tk[i] == TO) m_st[i] = 2;
        end
      end
    end
    if (gnt) begin m_st[g] = 1; m_tk[g] = 0; end
    e_count = 0;
    for (int i = 0; i < NT; i++) if (m_st[i] != 0) e_count++;
    e_allbusy = (e_count == NT);
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rst);
      if (!rst) model_reset();
      else model_step();
    end
  end

  // Compare process: every negedge, all outputs against the model
  logic c_gnt;
  int   c_ftag;
  initial begin
    forever begin
      @(negedge clk);
      c_ftag = lowest_free();
      c_gnt  = alloc_req && (c_ftag >= 0);
      chk("alloc_gnt", alloc_gnt, c_gnt);
      if (c_gnt) chk("alloc_tag", alloc_tag, c_ftag);
      chk("cpl_expected", cpl_expected, e_cexp);
      chk("cpl_unexpected", cpl_unexpected, e_cunexp);
      if (e_cexp || e_cunexp) chk("cpl_res_tag", cpl_res_tag, e_restag);
      chk("timeout_valid", timeout_valid, e_to);
      if (e_to) chk("timeout_tag", timeout_tag, e_totag);
      chk("outstanding_count", outstanding_count, e_count);
      chk("all_busy", all_busy, e_allbusy);
    end
  end

  task automatic nxt();
    @(posedge clk);
    #2;
  endtask

  task automatic clr();
    alloc_req = 1'b0; cpl_valid = 1'b0; cpl_last = 1'b0;
    cpl_req_id = '0; cpl_tag = '0; uc_en = 1'b1;
  endtask

  task automatic cpl(input logic [IDW-1:0] id, input int tag, input logic last);
    cpl_valid = 1'b1; cpl_req_id = id; cpl_tag = TW'(tag); cpl_last = last;
  endtask

  task automatic do_reset();
    clr();
    rst = 1'b0;
    nxt(); nxt();
    rst = 1'b1;
  endtask

  task automatic neg_chk_gnt(input string nm, input logic g, input int tag);
    @(negedge clk); #1;
    chk({nm, "_gnt"}, alloc_gnt, g);
    if (g) chk({nm, "_tag"}, alloc_tag, tag);
  endtask

  initial begin
    // Allocation order and completion classification
    do_reset();
    chk("rst_count", outstanding_count, 0);
    chk("rst_all_busy", all_busy, 0);
    for (int k = 0; k < NT; k++) begin
      alloc_req = 1'b1;
      neg_chk_gnt("p1_alloc", 1'b1, k);
      nxt();
    end
    chk("p1_full_count", outstanding_count, 4);
    chk("p1_all_busy", all_busy, 1);
    neg_chk_gnt("p1_fifth", 1'b0, 0);
    nxt();
    clr(); cpl(OWN, 2, 1'b0); nxt();
    chk("p1_exp_nl", cpl_expected, 1);
    chk("p1_exp_nl_cnt", outstanding_count, 4);
    cpl(OWN, 2, 1'b1); nxt();
    chk("p1_exp_l", cpl_expected, 1);
    chk("p1_exp_l_cnt", outstanding_count, 3);
    clr(); alloc_req = 1'b1;
    neg_chk_gnt("p1_realloc", 1'b1, 2);
    nxt();
    clr(); cpl(OWN ^ 16'h0001, 1, 1'b0); nxt();
    chk("p1_wrong_id_uc", cpl_unexpected, 1);
    chk("p1_wrong_id_tag", cpl_res_tag, 1);
    chk("p1_wrong_id_cnt", outstanding_count, 4);
    cpl(OWN, 7, 1'b1); nxt();
    chk("p1_tag7_uc", cpl_unexpected, 1);
    chk("p1_tag7_tag", cpl_res_tag, 7);
    uc_en = 1'b0; cpl(OWN ^ 16'h0001, 1, 1'b0); nxt();
    chk("p1_ucdis_uc", cpl_unexpected, 0);
    chk("p1_ucdis_exp", cpl_expected, 0);
    cpl(OWN, 7, 1'b1); nxt();
    chk("p1_ucdis7_uc", cpl_unexpected, 0);
    clr();
    repeat (16) nxt();

    // Completion freeing a tag while full: not grantable until next cycle
    do_reset();
    alloc_req = 1'b1;
    repeat (NT) nxt();
    cpl(OWN, 0, 1'b1);
    neg_chk_gnt("p2_same", 1'b0, 0);
    nxt();
    chk("p2_free_cnt", outstanding_count, 3);
    clr(); alloc_req = 1'b1;
    neg_chk_gnt("p2_next", 1'b1, 0);
    nxt();
    clr();

    // Timeout of two tags on one tick, reported on consecutive cycles
    do_reset();
    alloc_req = 1'b1;
    nxt(); nxt();
    clr();
    repeat (9) nxt();
    chk("p3_pre_cnt", outstanding_count, 2);
    chk("p3_pre_to", timeout_valid, 0);
    nxt();
    chk("p3_timed_cnt", outstanding_count, 2);
    chk("p3_timed_to", timeout_valid, 0);
    nxt();
    chk("p3_to0_v", timeout_valid, 1);
    chk("p3_to0_tag", timeout_tag, 0);
    chk("p3_to0_cnt", outstanding_count, 1);
    nxt();
    chk("p3_to1_v", timeout_valid, 1);
    chk("p3_to1_tag", timeout_tag, 1);
    chk("p3_to1_cnt", outstanding_count, 0);
    nxt();
    chk("p3_to_done", timeout_valid, 0);
    cpl(OWN, 0, 1'b1); nxt();
    chk("p3_late_uc", cpl_unexpected, 1);
    clr();

    // Reset with three tags outstanding
    do_reset();
    alloc_req = 1'b1;
    repeat (3) nxt();
    chk("p4_pre_cnt", outstanding_count, 3);
    rst = 1'b0;
    #1;
    chk("p4_rst_cnt", outstanding_count, 0);
    chk("p4_rst_busy", all_busy, 0);
    chk("p4_rst_exp", cpl_expected, 0);
    chk("p4_rst_to", timeout_valid, 0);
    chk("p4_rst_gnt", alloc_gnt, 1);
    nxt();
    rst = 1'b1;
    neg_chk_gnt("p4_first", 1'b1, 0);
    nxt();
    chk("p4_post_cnt", outstanding_count, 1);
    clr();

    // Randomized traffic; sparse-completion segments let timeouts accumulate
    do_reset();
    for (int seg = 0; seg < 6; seg++) begin
      for (int c = 0; c < 500; c++) begin
        alloc_req = ($urandom_range(0, 1) == 1);
        if (seg % 3 == 0) cpl_valid = ($urandom_range(0, 15) == 0);
        else cpl_valid = ($urandom_range(0, 1) == 1);
        cpl_req_id = ($urandom_range(0, 3) == 0) ? (OWN ^ IDW'($urandom_range(1, 65535))) : OWN;
        cpl_tag  = ($urandom_range(0, 7) == 0) ? TW'($urandom_range(0, 1023)) : TW'($urandom_range(0, NT - 1));
        cpl_last = ($urandom_range(0, 1) == 1);
        uc_en    = ($urandom_range(0, 7) != 0);
        if ($urandom_range(0, 999) == 0) begin
          rst = 1'b0;
          nxt();
          rst = 1'b1;
        end
        nxt();
      end
    end
    clr();
    nxt(); nxt();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
